clk_gate_ctrl: RTL and testbench
================================

// Module: clk_gate_ctrl
// PURPOSE
// - Idle-driven clock-gating controller for one gated clock domain; runs on the free-running clock.
// - Watches per-requester busy/wake lines, applies a programmable idle hysteresis, handshakes a quiesce request with the domain, then drives the enable of one icg cell.
// - Restores the clock on any wake or busy event, then reports the domain ready after a fixed settle time.
// PARAMETERS
// - N_REQ     4  number of requester busy/wake pairs (>=1)
// - IDLE_W    8  width of idle-threshold config and idle counter
// - WAKE_CYC  2  clock cycles from clock restore to rdy_o (>=1)
// PORTS
// - clk              in   1       free-running clock; all logic on rising edge
// - rst_n            in   1       asynchronous active-low reset
// - tst_en           in   1       scan/test: passed to icg tst_en, forces clkg on; FSM unaffected
// - cfg_gate_en      in   1       1 = gating allowed
// - cfg_idle_thresh  in   IDLE_W  idle cycles required before sleep request
// - busy_i           in   N_REQ   requester busy, level
// - wake_i           in   N_REQ   requester wake, level or pulse
// - slp_ack_i        in   1       domain quiesced, level, valid while slp_req_o=1
// - slp_req_o        out  1       quiesce request to domain
// - clk_en_o         out  1       registered icg enable (observable copy)
// - clkg             out  1       gated clock from icg instance
// - rdy_o            out  1       domain clocked and usable
// - gated_o          out  1       1 while in GATED
// BEHAVIOUR
// - act = |busy_i | |wake_i, combinational. All outputs registered except clkg.
// - Reset: state=RUN, clk_en_o=1, rdy_o=1, slp_req_o=0, gated_o=0, counter=0.
// - RUN: clk_en_o=1, rdy_o=1. If cfg_gate_en & !act -> IDLE_WAIT, cnt=0.
// - IDLE_WAIT: act or !cfg_gate_en -> RUN. Else cnt++ (saturates at 2^IDLE_W-1).
//   When cnt >= cfg_idle_thresh -> SLEEP_REQ. thresh=0 gives exactly one IDLE_WAIT cycle.
// - SLEEP_REQ: slp_req_o=1. act or !cfg_gate_en -> RUN, slp_req_o=0 next cycle (abort).
//   slp_ack_i & !act -> GATED. act has priority over ack on the same cycle.
// - GATED: clk_en_o=0, rdy_o=0, gated_o=1, slp_req_o stays 1. Min 1 cycle.
//   act or !cfg_gate_en -> WAKE.
// - WAKE: clk_en_o=1, slp_req_o=0, gated_o=0, rdy_o=0; cnt counts WAKE_CYC cycles -> RUN, rdy_o=1.
//   act during WAKE is ignored (already waking).
// - Wake latency: act sampled in GATED -> clk_en_o high next edge -> rdy_o high WAKE_CYC edges later.
// - cfg_idle_thresh changes take effect on the next compare; no retrigger.
// - rst_n low in any state: immediate return to reset values; clock ungated asynchronously.
// - tst_en=1: clkg follows clk regardless of clk_en_o; FSM and outputs unchanged.
// CONFIGURATION
// - CLK_GATE_CTRL_STATS_EN defined:
//   - adds output stat_gated_cnt [31:0]: cycles spent in GATED, wraps at 2^32.
//   - adds input stat_clr (1): synchronous clear, wins over increment.
// - Not defined: neither port exists; no counter logic.
// STRUCTURE
// - Package clk_gate_ctrl_pkg:
//   - typedef enum logic [2:0] cgc_state_e {CGC_RUN, CGC_IDLE_WAIT, CGC_SLEEP_REQ, CGC_GATED, CGC_WAKE}.
//   - localparam STAT_W = 32.
// - One sub-module: existing icg, instance u_icg (.clk, .en(clk_en_o), .tst_en, .clkg).
// - Idle and wake counting share one IDLE_W-bit counter; WAKE_CYC must fit in IDLE_W.
// TESTING
// - thresh=3, gate_en=1, all idle, ack 2 cycles after req -> slp_req_o after 4 idle cycles; clk_en_o=0 one cycle after ack; clkg flat.
// - In GATED, pulse wake_i[2] one cycle -> clk_en_o=1 next edge; rdy_o=1 exactly 2 edges later (WAKE_CYC=2); slp_req_o=0.
// - busy_i[0] rises in SLEEP_REQ on the same cycle slp_ack_i=1 -> RUN; slp_req_o drops; never GATED.
// - thresh=0 -> IDLE_WAIT lasts 1 cycle. thresh=255 with idle held 300 cycles -> cnt saturates, sleep requested once.
// - rst_n low while GATED -> clk_en_o=1, rdy_o=1, slp_req_o=0 immediately.
//   tst_en=1 while GATED -> clkg toggles; gated_o stays 1.
// - With CLK_GATE_CTRL_STATS_EN: gate 10 cycles -> stat_gated_cnt=10; stat_clr with GATED -> 0 next edge.

Source files
------------

// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the idle-driven clock-gating controller.
package clk_gate_ctrl_pkg;

    typedef enum logic [2:0] {
        CGC_RUN,
        CGC_IDLE_WAIT,
        CGC_SLEEP_REQ,
        CGC_GATED,
        CGC_WAKE
    } cgc_state_e;

    localparam int STAT_W = 32;

    // Quiesce request stays raised from the request phase through the gated phase.
    function automatic logic cgc_req_active(input cgc_state_e s);
        logic r;
        case (s)
            CGC_SLEEP_REQ: r = 1'b1;
            CGC_GATED:     r = 1'b1;
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_icg.sv
// Integrated clock-gating cell: enable captured while clk is low, so clkg
// never glitches; tst_en bypasses the enable for scan.
module icg (
    input  logic clk,
    input  logic en,
    input  logic tst_en,
    output logic clkg
);

    logic en_q;

    // enable sampled on the falling edge holds steady across the high phase
    always_ff @(negedge clk) begin
        en_q <= en;
    end

    assign clkg = clk & (en_q | tst_en);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-hysteresis clock-gating controller driving one icg cell.
// Optional gated-cycle statistics counter: define CLK_GATE_CTRL_STATS_EN.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tst_en,
    input  logic              cfg_gate_en,
    input  logic [IDLE_W-1:0] cfg_idle_thresh,
    input  logic [N_REQ-1:0]  busy_i,
    input  logic [N_REQ-1:0]  wake_i,
    input  logic              slp_ack_i,
    output logic              slp_req_o,
    output logic              clk_en_o,
    output logic              clkg,
    output logic              rdy_o,
    output logic              gated_o
`ifdef CLK_GATE_CTRL_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_gated_cnt
`endif
);

    localparam logic [IDLE_W-1:0] CNT_MAX   = {IDLE_W{1'b1}};
    localparam logic [IDLE_W-1:0] WAKE_LAST = IDLE_W'(WAKE_CYC - 1);

    function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] v);
        return (v == CNT_MAX) ? v : v + IDLE_W'(1'b1);
    endfunction

    cgc_state_e        state_q, state_d;
    logic [IDLE_W-1:0] cnt_q, cnt_d;
    logic              act_s;
    logic              slp_req_d, clk_en_d, rdy_d, gated_d;

    assign act_s = (|busy_i) | (|wake_i);

    // next-state: one counter serves both idle hysteresis and wake settle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CGC_RUN: begin
                if (cfg_gate_en && !act_s) begin
                    state_d = CGC_IDLE_WAIT;
                    cnt_d   = {IDLE_W{1'b0}};
                end else begin
                    state_d = CGC_RUN;
                end
            end
            CGC_IDLE_WAIT: begin
                if (act_s || !cfg_gate_en) begin
                    state_d = CGC_RUN;
                end else if (cnt_q >= cfg_idle_thresh) begin
                    state_d = CGC_SLEEP_REQ;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            CGC_SLEEP_REQ: begin
                // activity outranks an acknowledge arriving in the same cycle
                if (act_s || !cfg_gate_en) begin
                    state_d = CGC_RUN;
                end else if (slp_ack_i) begin
                    state_d = CGC_GATED;
                end else begin
                    state_d = CGC_SLEEP_REQ;
                end
            end
            CGC_GATED: begin
                if (act_s || !cfg_gate_en) begin
                    state_d = CGC_WAKE;
                    cnt_d   = {IDLE_W{1'b0}};
                end else begin
                    state_d = CGC_GATED;
                end
            end
            CGC_WAKE: begin
                if (cnt_q >= WAKE_LAST) begin
                    state_d = CGC_RUN;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = CGC_RUN;
                cnt_d   = {IDLE_W{1'b0}};
            end
        endcase
    end

    // output decode from the next state so every output is a flop
    always_comb begin
        slp_req_d = cgc_req_active(state_d);
        clk_en_d  = 1'b1;
        rdy_d     = 1'b1;
        gated_d   = 1'b0;
        case (state_d)
            CGC_GATED: begin
                clk_en_d = 1'b0;
                rdy_d    = 1'b0;
                gated_d  = 1'b1;
            end
            CGC_WAKE: begin
                rdy_d = 1'b0;
            end
            default: begin
                rdy_d = 1'b1;
            end
        endcase
    end

    // state, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CGC_RUN;
            cnt_q     <= {IDLE_W{1'b0}};
            slp_req_o <= 1'b0;
            clk_en_o  <= 1'b1;
            rdy_o     <= 1'b1;
            gated_o   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slp_req_o <= slp_req_d;
            clk_en_o  <= clk_en_d;
            rdy_o     <= rdy_d;
            gated_o   <= gated_d;
        end
    end

    icg u_icg (
        .clk    (clk),
        .en     (clk_en_o),
        .tst_en (tst_en),
        .clkg   (clkg)
    );

`ifdef CLK_GATE_CTRL_STATS_EN
    logic [STAT_W-1:0] stat_q;

    // gated-cycle counter, clear outranks increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= {STAT_W{1'b0}};
        end else if (stat_clr) begin
            stat_q <= {STAT_W{1'b0}};
        end else if (state_q == CGC_GATED) begin
            stat_q <= stat_q + STAT_W'(1'b1);
        end else begin
            stat_q <= stat_q;
        end
    end

    assign stat_gated_cnt = stat_q;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with a phase/streak reference model.
module tb_clk_gate_ctrl;

    localparam int N_REQ    = 4;
    localparam int IDLE_W   = 8;
    localparam int WAKE_CYC = 2;

    logic             clk = 1'b0;
    logic             rst_n, tst_en, cfg_gate_en, slp_ack_i;
    logic [IDLE_W-1:0] cfg_idle_thresh;
    logic [N_REQ-1:0] busy_i, wake_i;
    logic             slp_req_o, clk_en_o, clkg, rdy_o, gated_o;
`ifdef CLK_GATE_CTRL_STATS_EN
    logic             stat_clr;
    logic [31:0]      stat_gated_cnt;
`endif

    int tests = 0;
    int fails = 0;

    clk_gate_ctrl #(.N_REQ(N_REQ), .IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tst_en          (tst_en),
        .cfg_gate_en     (cfg_gate_en),
        .cfg_idle_thresh (cfg_idle_thresh),
        .busy_i          (busy_i),
        .wake_i          (wake_i),
        .slp_ack_i       (slp_ack_i),
        .slp_req_o       (slp_req_o),
        .clk_en_o        (clk_en_o),
        .clkg            (clkg),
        .rdy_o           (rdy_o),
        .gated_o         (gated_o)
`ifdef CLK_GATE_CTRL_STATS_EN
        ,
        .stat_clr        (stat_clr),
        .stat_gated_cnt  (stat_gated_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model. Phases: 0 awake (not asking), 1 requesting, 2 gated, 3 waking.
    // Sleep is requested once the number of consecutive eligible edges, less one
    // (capped at 255), reaches the threshold, after at least one eligible edge.
    int   m_phase, m_streak, m_wake_left;
    bit   e_req, e_en, e_rdy, e_gated, last_en;
    int unsigned e_stat;

    always @(posedge clk or negedge rst_n) begin : mdl
        int ph, stk, wl, held;
        bit stop;
        if (!rst_n) begin
            m_phase <= 0; m_streak <= 0; m_wake_left <= 0;
            e_req <= 1'b0; e_en <= 1'b1; e_rdy <= 1'b1; e_gated <= 1'b0;
            e_stat <= 0;
        end else begin
            ph = m_phase; stk = m_streak; wl = m_wake_left;
            stop = (|busy_i) || (|wake_i) || !cfg_gate_en;
            if (ph == 0) begin
                if (stop) stk = 0;
                else begin
                    held = (stk - 1 > 255) ? 255 : stk - 1;
                    if (stk >= 1 && held >= int'(cfg_idle_thresh)) begin ph = 1; stk = 0; end
                    else stk = stk + 1;
                end
            end else if (ph == 1) begin
                if (stop) ph = 0;
                else if (slp_ack_i) ph = 2;
            end else if (ph == 2) begin
                if (stop) begin ph = 3; wl = WAKE_CYC; end
            end else begin
                wl = wl - 1;
                if (wl == 0) begin ph = 0; stk = 0; end
            end
`ifdef CLK_GATE_CTRL_STATS_EN
            if (stat_clr) e_stat <= 0;
            else if (m_phase == 2) e_stat <= e_stat + 1;
`endif
            m_phase <= ph; m_streak <= stk; m_wake_left <= wl;
            e_req   <= (ph == 1) || (ph == 2);
            e_en    <= (ph != 2);
            e_rdy   <= (ph == 0) || (ph == 1);
            e_gated <= (ph == 2);
        end
    end

    // the gate cell sees the enable as it stood at the last falling edge
    always @(negedge clk) last_en <= e_en;

    // per-cycle output comparison
    always @(negedge clk) begin
        if (rst_n) begin
            chk("slp_req", slp_req_o, e_req);
            chk("clk_en", clk_en_o, e_en);
            chk("rdy", rdy_o, e_rdy);
            chk("gated", gated_o, e_gated);
`ifdef CLK_GATE_CTRL_STATS_EN
            chk("stat", stat_gated_cnt, e_stat);
`endif
        end
    end

    // gated clock during the high phase
    always @(posedge clk) begin
        #2;
        if (rst_n) chk("clkg_hi", clkg, last_en | tst_en);
    end

    task automatic wait_req(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!slp_req_o && n < 400);
    endtask

    task automatic wait_gated();
        int k;
        k = 0;
        while (!gated_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("gated_reached", gated_o, 1);
    endtask

    initial begin
        int n, rises;
        bit prev;
        rst_n = 1'b0; tst_en = 1'b0; cfg_gate_en = 1'b0; cfg_idle_thresh = 8'd3;
        busy_i = 4'b0000; wake_i = 4'b0000; slp_ack_i = 1'b0;
`ifdef CLK_GATE_CTRL_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_clk_en", clk_en_o, 1); chk("rst_rdy", rdy_o, 1);
        chk("rst_slp_req", slp_req_o, 0); chk("rst_gated", gated_o, 0);
        rst_n = 1'b1;

        // thresh=3: four idle-wait cycles, request on the fifth edge of idleness
        cfg_gate_en = 1'b1; busy_i = 4'b0001;
        repeat (3) @(negedge clk);
        busy_i = 4'b0000;
        wait_req(n);
        chk("idle3_to_req", n, 5);
        @(negedge clk); slp_ack_i = 1'b1;
        @(negedge clk);
        chk("ack_clk_en", clk_en_o, 0); chk("ack_gated", gated_o, 1);
        @(posedge clk); #2 chk("clkg_flat_hi", clkg, 0);
        @(negedge clk); #2 chk("clkg_flat_lo", clkg, 0);

        // one-cycle wake pulse from requester 2
        @(negedge clk); wake_i = 4'b0100; slp_ack_i = 1'b0;
        @(negedge clk); wake_i = 4'b0000;
        chk("wake_clk_en", clk_en_o, 1); chk("wake_rdy0", rdy_o, 0); chk("wake_req", slp_req_o, 0);
        @(negedge clk); chk("wake_rdy1", rdy_o, 0);
        @(negedge clk); chk("wake_rdy2", rdy_o, 1);
        busy_i = 4'b0001; cfg_idle_thresh = 8'd0;

        // thresh=0: a single idle-wait cycle
        @(negedge clk); busy_i = 4'b0000;
        wait_req(n);
        chk("idle0_to_req", n, 2);
        // busy and ack together: activity wins
        @(negedge clk); busy_i = 4'b0001; slp_ack_i = 1'b1;
        @(negedge clk);
        chk("race_req", slp_req_o, 0); chk("race_gated", gated_o, 0); chk("race_rdy", rdy_o, 1);
        repeat (4) @(negedge clk);
        chk("race_never_gated", gated_o, 0);
        slp_ack_i = 1'b0; cfg_idle_thresh = 8'd255;

        // thresh=255 with 300 idle cycles: exactly one request
        @(negedge clk); busy_i = 4'b0000;
        wait_req(n);
        chk("idle255_to_req", n, 257);
        rises = 0; prev = slp_req_o;
        repeat (43) begin
            @(negedge clk);
            if (slp_req_o && !prev) rises++;
            prev = slp_req_o;
        end
        chk("req_rises", rises, 0); chk("req_held", slp_req_o, 1);

        // asynchronous reset while gated
        slp_ack_i = 1'b1;
        @(negedge clk); chk("gated_for_rst", gated_o, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_clk_en", clk_en_o, 1); chk("arst_rdy", rdy_o, 1);
        chk("arst_req", slp_req_o, 0); chk("arst_gated", gated_o, 0);
        cfg_idle_thresh = 8'd0;
        @(negedge clk); rst_n = 1'b1;
        wait_gated();

        // scan bypass while gated
        @(negedge clk); tst_en = 1'b1;
        @(posedge clk); #2 chk("tst_clkg_hi", clkg, 1); chk("tst_gated", gated_o, 1);
        @(negedge clk); #2 chk("tst_clkg_lo", clkg, 0);
        @(negedge clk); tst_en = 1'b0;
        cfg_gate_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("disable_wakes", rdy_o, 1);

`ifdef CLK_GATE_CTRL_STATS_EN
        stat_clr = 1'b1;
        @(negedge clk); stat_clr = 1'b0; cfg_gate_en = 1'b1;
        wait_gated();
        repeat (9) @(negedge clk);
        busy_i = 4'b0001;
        @(negedge clk); chk("stat_ten", stat_gated_cnt, 10);
        busy_i = 4'b0000;
        wait_gated();
        @(negedge clk); stat_clr = 1'b1;
        @(negedge clk); stat_clr = 1'b0;
        chk("stat_clr", stat_gated_cnt, 0);
        busy_i = 4'b0001;
`endif
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
